// File: rtl/phase_pkg.sv
// Shared definitions for the phase measurement blocks: reference period,
// phase width, detector FSM encoding and circular phase distance.
package phase_pkg;

  localparam int COUNTS_PER_PERIOD = 128;
  localparam int PHASE_W           = 7;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } pd_state_t;

  // Shortest distance between two phases on the wrapping 7-bit circle.
  function automatic phase_t circ_diff(input phase_t a, input phase_t b);
    phase_t d_ab;
    phase_t d_ba;
    d_ab = a - b;
    d_ba = b - a;
    return (d_ab < d_ba) ? d_ab : d_ba;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clock_slow domain.
module sync_2ff (
  input  logic clock_slow,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clock_slow or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/phase_detector.sv
// Measures the phase of signal_in rising edges against a free-running reference
// counter, checks period stability and tracks lock on a stable phase.
module phase_detector #(
  parameter int COUNTS_PER_PERIOD = phase_pkg::COUNTS_PER_PERIOD,
  parameter int PERIOD_TOL        = 2,
  parameter int PHASE_TOL         = 2,
  parameter int LOCK_COUNT        = 4,
  parameter int LATENCY           = 3
) (
  input  logic       clock_slow,
  input  logic       reset_n,
  input  logic       signal_in,
  input  logic       ref_clear,
  output logic [6:0] phase_out,
  output logic       phase_valid,
  output logic       period_error,
  output logic       locked
);

  import phase_pkg::phase_t;
  import phase_pkg::pd_state_t;
  import phase_pkg::ST_IDLE;
  import phase_pkg::ST_MEASURE;
  import phase_pkg::ST_LOCKED;
  import phase_pkg::circ_diff;

  localparam int                GOOD_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [8:0]        PERIOD_LO   = 9'(COUNTS_PER_PERIOD - PERIOD_TOL);
  localparam logic [8:0]        PERIOD_HI   = 9'(COUNTS_PER_PERIOD + PERIOD_TOL);
  localparam logic [8:0]        TIMEOUT_CNT = 9'(2 * COUNTS_PER_PERIOD);
  localparam logic [8:0]        PERIOD_MAX  = 9'h1FF;
  localparam phase_t            LATENCY_P   = phase_t'(LATENCY);
  localparam phase_t            PHASE_TOL_P = phase_t'(PHASE_TOL);
  localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_COUNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE    = GOOD_W'(1);

  logic              sig_sync;
  logic              sig_dly;
  logic              edge_det;
  phase_t            ref_count;
  phase_t            capture_phase;
  phase_t            prev_phase;
  logic [8:0]        period_cnt;
  logic              period_good;
  logic              phase_close;
  logic              timeout;
  pd_state_t         state_q;
  pd_state_t         state_d;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_d;
  phase_t            phase_d;
  logic              valid_d;
  logic              error_d;

  sync_2ff u_sync (
    .clock_slow (clock_slow),
    .reset_n    (reset_n),
    .din        (signal_in),
    .dout       (sig_sync)
  );

  assign edge_det      = sig_sync & ~sig_dly;
  assign capture_phase = ref_count - LATENCY_P;
  assign period_good   = (period_cnt >= PERIOD_LO) && (period_cnt <= PERIOD_HI);
  assign phase_close   = circ_diff(capture_phase, prev_phase) <= PHASE_TOL_P;
  assign timeout       = !edge_det && (period_cnt == TIMEOUT_CNT);

  // period_cnt stays at zero until the first edge so an idle input never times out.
  always_ff @(posedge clock_slow or negedge reset_n) begin
    if (!reset_n) begin
      sig_dly    <= 1'b0;
      ref_count  <= '0;
      period_cnt <= '0;
      prev_phase <= '0;
    end else begin
      sig_dly   <= sig_sync;
      ref_count <= ref_clear ? phase_t'(0) : ref_count + phase_t'(1);
      if (edge_det) begin
        period_cnt <= 9'd1;
        prev_phase <= capture_phase;
      end else if ((period_cnt != '0) && (period_cnt != PERIOD_MAX)) begin
        period_cnt <= period_cnt + 9'd1;
      end
    end
  end

  always_ff @(posedge clock_slow or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      good_cnt     <= '0;
      phase_out    <= '0;
      phase_valid  <= 1'b0;
      period_error <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_cnt     <= good_d;
      phase_out    <= phase_d;
      phase_valid  <= valid_d;
      period_error <= error_d;
      locked       <= (state_d == ST_LOCKED);
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_cnt;
    phase_d = phase_out;
    valid_d = 1'b0;
    error_d = 1'b0;
    if (edge_det) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
        ST_MEASURE: begin
          if (period_good) begin
            phase_d = capture_phase;
            valid_d = 1'b1;
            if (phase_close) begin
              good_d = (good_cnt >= LOCK_TARGET) ? good_cnt : good_cnt + GOOD_ONE;
            end else begin
              good_d = GOOD_ONE;
            end
            if (good_d >= LOCK_TARGET) begin
              state_d = ST_LOCKED;
            end
          end else begin
            error_d = 1'b1;
            good_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (period_good) begin
            phase_d = capture_phase;
            valid_d = 1'b1;
            if (!phase_close) begin
              state_d = ST_MEASURE;
              good_d  = GOOD_ONE;
            end
          end else begin
            error_d = 1'b1;
            state_d = ST_MEASURE;
            good_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          good_d  = '0;
        end
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
      error_d = 1'b1;
      good_d  = '0;
    end
  end

endmodule

// File: tb/tb_phase_detector.sv
// Bench for phase_detector: table-driven edge trains with a scoreboard of
// expected strobes, plus hand-written timeout, ref_clear and reset sequences.
module tb_phase_detector;

  typedef enum int {K_NONE = 0, K_VALID = 1, K_ERROR = 2} kind_t;

  typedef struct {
    int    gap;
    kind_t kind;
    int    phase;
    bit    lock;
  } vec_t;

  typedef struct {
    kind_t kind;
    int    phase;
    bit    lock;
  } exp_t;

  logic       clock_slow = 1'b0;
  logic       reset_n    = 1'b0;
  logic       signal_in  = 1'b0;
  logic       ref_clear  = 1'b0;
  logic [6:0] phase_out;
  logic       phase_valid;
  logic       period_error;
  logic       locked;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   tb_ref   = 0;
  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;

  phase_detector dut (
    .clock_slow   (clock_slow),
    .reset_n      (reset_n),
    .signal_in    (signal_in),
    .ref_clear    (ref_clear),
    .phase_out    (phase_out),
    .phase_valid  (phase_valid),
    .period_error (period_error),
    .locked       (locked)
  );

  always #5 clock_slow = ~clock_slow;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Bench copy of the reference counter, advanced once per rising clock edge.
  task automatic tick();
    @(posedge clock_slow);
    if (!reset_n || ref_clear) tb_ref = 0;
    else tb_ref = (tb_ref + 1) % 128;
    #1;
  endtask

  task automatic wait_ref(input int target);
    for (int i = 0; i < 130 && tb_ref != target; i++) tick();
  endtask

  // A rise launched while the reference reads P+1 is captured as phase P.
  task automatic apply_stimulus(input vec_t v);
    if (v.gap < 0) wait_ref((v.phase + 1) % 128);
    else repeat (v.gap - 20) tick();
    if (v.kind != K_NONE) sb.push_back('{kind: v.kind, phase: v.phase, lock: v.lock});
    signal_in = 1'b1;
    repeat (20) tick();
    signal_in = 1'b0;
  endtask

  task automatic add_vec(input int gap, input kind_t k, input int ph, input bit lk);
    vecs.push_back('{gap: gap, kind: k, phase: ph, lock: lk});
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) apply_stimulus(vecs[i]);
    vecs.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  always @(negedge clock_slow) begin
    if (reset_n && (phase_valid || period_error)) begin
      check_output("strobe_exclusive", int'(phase_valid & period_error), 0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_strobe: got valid=%0d error=%0d, required none",
                 phase_valid, period_error);
      end else begin
        mon_e = sb.pop_front();
        check_output("event_kind", phase_valid ? 1 : 2, int'(mon_e.kind));
        check_output("phase_out", int'(phase_out), mon_e.phase);
        check_output("locked_at_event", int'(locked), int'(mon_e.lock));
      end
    end
  end

  initial begin
    #700000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) tick();
    check_output("rst_phase_out", int'(phase_out), 0);
    check_output("rst_phase_valid", int'(phase_valid), 0);
    check_output("rst_period_error", int'(period_error), 0);
    check_output("rst_locked", int'(locked), 0);
    reset_n = 1'b1;

    // Lock at 40, bad period, relock, tolerance boundaries.
    add_vec(-1,  K_NONE,  40, 0);
    add_vec(128, K_VALID, 40, 0);
    add_vec(128, K_VALID, 40, 0);
    add_vec(128, K_VALID, 40, 0);
    add_vec(128, K_VALID, 40, 1);
    add_vec(128, K_VALID, 40, 1);
    add_vec(140, K_ERROR, 40, 0);
    add_vec(128, K_VALID, 52, 0);
    add_vec(128, K_VALID, 52, 0);
    add_vec(128, K_VALID, 52, 0);
    add_vec(128, K_VALID, 52, 1);
    add_vec(129, K_VALID, 53, 1);
    add_vec(130, K_VALID, 55, 1);
    add_vec(131, K_ERROR, 55, 0);
    add_vec(126, K_VALID, 56, 0);
    add_vec(126, K_VALID, 54, 0);
    add_vec(125, K_ERROR, 54, 0);
    add_vec(128, K_VALID, 51, 0);
    add_vec(128, K_VALID, 51, 0);
    add_vec(128, K_VALID, 51, 0);
    add_vec(128, K_VALID, 51, 1);
    run_vecs();
    check_output("locked_before_timeout", int'(locked), 1);

    // Input held low: one timeout error, then IDLE handling of the next edge.
    sb.push_back('{kind: K_ERROR, phase: 51, lock: 1'b0});
    repeat (300) tick();
    check_output("timeout_consumed", sb.size(), 0);
    check_output("timeout_unlocked", int'(locked), 0);
    add_vec(-1,  K_NONE,  10, 0);
    add_vec(128, K_VALID, 10, 0);
    run_vecs();

    // Lock across the 127 -> 1 wrap.
    do_reset();
    add_vec(-1,  K_NONE,  127, 0);
    add_vec(128, K_VALID, 127, 0);
    add_vec(128, K_VALID, 127, 0);
    add_vec(128, K_VALID, 127, 0);
    add_vec(128, K_VALID, 127, 1);
    add_vec(130, K_VALID, 1,   1);
    run_vecs();

    // ref_clear mid-period shifts the phase by 64: lock drops, then recovers.
    repeat (41) tick();
    ref_clear = 1'b1;
    tick();
    ref_clear = 1'b0;
    add_vec(86,  K_VALID, 65, 0);
    add_vec(128, K_VALID, 65, 0);
    add_vec(128, K_VALID, 65, 0);
    add_vec(128, K_VALID, 65, 1);
    run_vecs();

    // ref_clear on the detection cycle (reference at 73) still captures 70.
    do_reset();
    add_vec(-1, K_NONE, 70, 0);
    run_vecs();
    repeat (108) tick();
    sb.push_back('{kind: K_VALID, phase: 70, lock: 1'b0});
    signal_in = 1'b1;
    tick();
    tick();
    ref_clear = 1'b1;
    tick();
    ref_clear = 1'b0;
    repeat (17) tick();
    signal_in = 1'b0;
    add_vec(128, K_VALID, 124, 0);
    add_vec(128, K_VALID, 124, 0);
    add_vec(128, K_VALID, 124, 0);
    add_vec(128, K_VALID, 124, 1);
    run_vecs();

    // Reset asserted mid-period while locked clears outputs immediately.
    repeat (50) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midrst_phase_out", int'(phase_out), 0);
    check_output("midrst_phase_valid", int'(phase_valid), 0);
    check_output("midrst_period_error", int'(period_error), 0);
    check_output("midrst_locked", int'(locked), 0);
    tick();
    reset_n = 1'b1;
    add_vec(-1, K_NONE, 20, 0);
    run_vecs();
    check_output("first_edge_phase_out", int'(phase_out), 0);
    check_output("first_edge_locked", int'(locked), 0);
    add_vec(128, K_VALID, 20, 0);
    run_vecs();

    repeat (10) tick();
    check_output("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
